// File: rtl/skinny_run_sequencer.sv
// Batch sequencer for the masked SKINNY-128-384+ core: refresh randomness, run, capture, idle gap, repeat.
// Optional build macro SKINNY_SEQ_PT_INC_EN steps the plaintext by one after every captured run.
module skinny_run_sequencer #(
  parameter int CT_W        = 256,
  parameter int PT_W        = 256,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] cfg_runs_i,
  input  logic [CNT_W-1:0] cfg_gap_i,
  input  logic [PT_W-1:0]  pt_seed_i,
  output logic             rand_req_o,
  input  logic             rand_ack_i,
  output logic             core_start_o,
  input  logic             core_done_i,
  input  logic [CT_W-1:0]  core_ct_i,
  output logic [PT_W-1:0]  pt_o,
  output logic [CT_W-1:0]  ct_o,
  output logic             ct_valid_o,
  output logic [CNT_W-1:0] runs_done_o,
  output logic             busy_o,
  output logic             batch_done_o,
  output logic             timeout_o,
  output logic             trigger_o
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFRESH,
    S_RUN,
    S_CAPTURE,
    S_GAP
  } state_e;

  state_e           state_q,    state_d;
  logic [TO_W-1:0]  runCnt_q,   runCnt_d;
  logic [CNT_W-1:0] gapCnt_q,   gapCnt_d;
  logic [CNT_W-1:0] runsCfg_q,  runsCfg_d;
  logic [CNT_W-1:0] gapCfg_q,   gapCfg_d;
  logic [CNT_W-1:0] runsDone_q, runsDone_d;
  logic [PT_W-1:0]  pt_q,       pt_d;
  logic [CT_W-1:0]  ct_q,       ct_d;
  logic             timeout_q,  timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      runCnt_q   <= '0;
      gapCnt_q   <= '0;
      runsCfg_q  <= '0;
      gapCfg_q   <= '0;
      runsDone_q <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      runCnt_q   <= runCnt_d;
      gapCnt_q   <= gapCnt_d;
      runsCfg_q  <= runsCfg_d;
      gapCfg_q   <= gapCfg_d;
      runsDone_q <= runsDone_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      timeout_q  <= timeout_d;
    end
  end

  // Ciphertext and run count are taken on the done edge so ct_o is already valid during CAPTURE.
  always_comb begin
    state_d    = state_q;
    runCnt_d   = runCnt_q;
    gapCnt_d   = gapCnt_q;
    runsCfg_d  = runsCfg_q;
    gapCfg_d   = gapCfg_q;
    runsDone_d = runsDone_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    timeout_d  = timeout_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i && (cfg_runs_i != '0)) begin
            runsCfg_d  = cfg_runs_i;
            gapCfg_d   = cfg_gap_i;
            pt_d       = pt_seed_i;
            runsDone_d = '0;
            timeout_d  = 1'b0;
            state_d    = S_REFRESH;
          end
        end
        S_REFRESH: begin
          if (rand_ack_i) begin
            runCnt_d = '0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (core_done_i) begin
            ct_d       = core_ct_i;
            runsDone_d = runsDone_q + CNT_W'(1);
            state_d    = S_CAPTURE;
          end else if (runCnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            runCnt_d = runCnt_q + TO_W'(1);
          end
        end
        S_CAPTURE: begin
`ifdef SKINNY_SEQ_PT_INC_EN
          pt_d = pt_q + PT_W'(1);
`endif
          gapCnt_d = gapCfg_q;
          if (runsDone_q == runsCfg_q) begin
            state_d = S_IDLE;
          end else if (gapCfg_q == '0) begin
            state_d = S_REFRESH;
          end else begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (gapCnt_q <= CNT_W'(1)) begin
            state_d = S_REFRESH;
          end else begin
            gapCnt_d = gapCnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rand_req_o   = (state_q == S_REFRESH);
  assign core_start_o = (state_q == S_RUN);
  assign trigger_o    = core_start_o;
  assign ct_valid_o   = (state_q == S_CAPTURE);
  assign batch_done_o = (state_q == S_CAPTURE) && (runsDone_q == runsCfg_q) && !abort_i;
  assign busy_o       = (state_q != S_IDLE);
  assign runs_done_o  = runsDone_q;
  assign timeout_o    = timeout_q;
  assign pt_o         = pt_q;
  assign ct_o         = ct_q;

endmodule

// File: tb/tb_skinny_run_sequencer.sv
// Scoreboard bench for skinny_run_sequencer; a second instance with a short timeout covers the RUN watchdog.
module tb_skinny_run_sequencer;

  localparam logic [255:0] CT_A5   = {32{8'hA5}};
  localparam logic [255:0] CT_3C   = {32{8'h3C}};
  localparam logic [255:0] CT_5A   = {32{8'h5A}};
  localparam logic [255:0] CT_C3   = {32{8'hC3}};
  localparam logic [255:0] SEED_1  = 256'h0123_4567_89AB_CDEF;
  localparam logic [255:0] PT_SEED = {{31{8'h12}}, 8'hFF};
  localparam logic [255:0] PT_NEXT = {{30{8'h12}}, 16'h1300};
  localparam logic [255:0] PT_LAST = {{30{8'h12}}, 16'h1301};

  typedef struct {
    logic [255:0] ct;
    logic [15:0]  runs;
    logic         bd;
    logic [255:0] pt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, go, abort, goB;
  logic [15:0]  cfgRuns, cfgGap;
  logic [255:0] ptSeed, coreCt;
  logic         randAck, coreDone;
  logic         randReq, coreStart, ctValid, busy, batchDone, timeoutFlag, trigger;
  logic [255:0] ptOut, ctOut;
  logic [15:0]  runsDone;
  logic         randReqB, coreStartB, ctValidB, busyB, batchDoneB, timeoutB, triggerB;
  logic [255:0] ptOutB, ctOutB;
  logic [15:0]  runsDoneB;

  int   checks = 0;
  int   errors = 0;
  int   doneDelay = 50;
  int   ackDelay = 1;
  int   startCnt = 0;
  int   reqCnt = 0;
  int   expGap = 0;
  int   gapMeas = 0;
  logic gapTiming = 1'b0;
  logic expStart = 1'b0;
  logic expValid = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  skinny_run_sequencer dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .abort_i(abort),
    .cfg_runs_i(cfgRuns), .cfg_gap_i(cfgGap), .pt_seed_i(ptSeed),
    .rand_req_o(randReq), .rand_ack_i(randAck),
    .core_start_o(coreStart), .core_done_i(coreDone), .core_ct_i(coreCt),
    .pt_o(ptOut), .ct_o(ctOut), .ct_valid_o(ctValid), .runs_done_o(runsDone),
    .busy_o(busy), .batch_done_o(batchDone), .timeout_o(timeoutFlag), .trigger_o(trigger)
  );

  skinny_run_sequencer #(.TIMEOUT_CYC(16)) dutTo (
    .clk_i(clk), .rst_i(rst), .go_i(goB), .abort_i(1'b0),
    .cfg_runs_i(cfgRuns), .cfg_gap_i(cfgGap), .pt_seed_i(ptSeed),
    .rand_req_o(randReqB), .rand_ack_i(randReqB),
    .core_start_o(coreStartB), .core_done_i(1'b0), .core_ct_i(256'h0),
    .pt_o(ptOutB), .ct_o(ctOutB), .ct_valid_o(ctValidB), .runs_done_o(runsDoneB),
    .busy_o(busyB), .batch_done_o(batchDoneB), .timeout_o(timeoutB), .trigger_o(triggerB)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  function automatic logic [255:0] ptAt(input logic [255:0] seed, input int idx);
`ifdef SKINNY_SEQ_PT_INC_EN
    return seed + 256'(idx);
`else
    return seed;
`endif
  endfunction

  task automatic pushRuns(input int total, input int pushCnt, input logic [255:0] ct, input logic [255:0] seed);
    exp_t e;
    for (int i = 0; i < pushCnt; i++) begin
      e.ct   = ct;
      e.runs = 16'(i + 1);
      e.bd   = (i == total - 1);
      e.pt   = ptAt(seed, i);
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int runs, input int gap, input logic [255:0] seed,
                               input logic [255:0] ct, input int delay, input logic onB);
    cfgRuns   = 16'(runs);
    cfgGap    = 16'(gap);
    ptSeed    = seed;
    coreCt    = ct;
    doneDelay = delay;
    expGap    = gap;
    @(negedge clk);
    if (onB) goB = 1'b1;
    else     go  = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    goB = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow("wait_idle_bound");
  endtask

  task automatic waitRunsDone(input logic [15:0] target, input int bound);
    int n = 0;
    while (runsDone != target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (runsDone != target) failNow("wait_runs_bound");
  endtask

  // Core and randomness-source stand-ins react one delta after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst && coreStart) begin
      startCnt++;
      coreDone = (startCnt == doneDelay);
    end else begin
      startCnt = 0;
      coreDone = 1'b0;
    end
    if (!rst && randReq) begin
      reqCnt++;
      randAck = (reqCnt == ackDelay + 1);
    end else begin
      reqCnt  = 0;
      randAck = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expStart  = 1'b0;
      expValid  = 1'b0;
      gapTiming = 1'b0;
    end else begin
      if (expStart) checkOutput("ack_to_start", coreStart, 1);
      if (expValid) checkOutput("done_to_ctvalid", ctValid, 1);
      if (ctValid) begin
        if (sb.size() == 0) begin
          failNow("unexpected_ct_valid");
        end else begin
          e = sb.pop_front();
          checkOutput("ct_o", ctOut, e.ct);
          checkOutput("runs_done_at_capture", runsDone, e.runs);
          checkOutput("batch_done_at_capture", batchDone, e.bd);
          checkOutput("pt_at_capture", ptOut, e.pt);
        end
      end else if (batchDone) begin
        failNow("batch_done_without_ct_valid");
      end
      if (gapTiming) begin
        gapMeas++;
        if (randReq) begin
          checkOutput("gap_cycles", gapMeas, expGap + 1);
          gapTiming = 1'b0;
        end else if (gapMeas > 200) begin
          failNow("gap_bound");
          gapTiming = 1'b0;
        end
      end
      if (ctValid && !batchDone) begin
        gapTiming = 1'b1;
        gapMeas   = 0;
      end
      expStart = randReq && randAck && !abort;
      expValid = coreStart && coreDone && !abort;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int bdSeen;
    rst = 1'b1; go = 1'b0; goB = 1'b0; abort = 1'b0;
    cfgRuns = '0; cfgGap = '0; ptSeed = '0; coreCt = '0;
    randAck = 1'b0; coreDone = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rand_req", randReq, 0);
    checkOutput("rst_core_start", coreStart, 0);
    checkOutput("rst_trigger", trigger, 0);
    checkOutput("rst_ct_valid", ctValid, 0);
    checkOutput("rst_batch_done", batchDone, 0);
    checkOutput("rst_timeout", timeoutFlag, 0);
    checkOutput("rst_runs_done", runsDone, 0);
    checkOutput("rst_ct", ctOut, 0);
    checkOutput("rst_pt", ptOut, 0);
    checkOutput("rst_busy_b", busyB, 0);

    $display("[TB] basic batch runs=3 gap=2");
    pushRuns(3, 3, CT_A5, SEED_1);
    applyStimulus(3, 2, SEED_1, CT_A5, 50, 1'b0);
    checkOutput("go_to_req", randReq, 1);
    checkOutput("busy_after_go", busy, 1);
    waitRunsDone(16'd1, 300);
    cfgRuns = 16'd7;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    waitIdle(1000);
    checkOutput("basic_runs_done", runsDone, 3);
    checkOutput("basic_timeout", timeoutFlag, 0);
    checkOutput("basic_pt_after", ptOut, ptAt(SEED_1, 3));

    $display("[TB] zero gap runs=2");
    pushRuns(2, 2, CT_3C, SEED_1);
    applyStimulus(2, 0, SEED_1, CT_3C, 4, 1'b0);
    checkOutput("zgap_go_to_req", randReq, 1);
    waitIdle(300);
    checkOutput("zgap_runs_done", runsDone, 2);

    $display("[TB] zero runs ignored");
    applyStimulus(0, 3, SEED_1, CT_5A, 4, 1'b0);
    checkOutput("zruns_busy", busy, 0);
    checkOutput("zruns_rand_req", randReq, 0);
    checkOutput("zruns_runs_done", runsDone, 2);
    checkOutput("zruns_ct_kept", ctOut, CT_3C);
    repeat (3) @(negedge clk);
    checkOutput("zruns_busy_later", busy, 0);

    $display("[TB] timeout on short-timeout instance");
    applyStimulus(1, 0, SEED_1, CT_5A, 4, 1'b1);
    n = 0; bdSeen = 0;
    for (int i = 0; i < 200 && busyB; i++) begin
      @(negedge clk);
      if (coreStartB) n++;
      if (batchDoneB) bdSeen++;
    end
    checkOutput("to_run_cycles", n, 16);
    checkOutput("to_flag", timeoutB, 1);
    checkOutput("to_core_start", coreStartB, 0);
    checkOutput("to_busy", busyB, 0);
    checkOutput("to_no_batch_done", bdSeen, 0);
    checkOutput("to_no_ct_valid", runsDoneB, 0);
    applyStimulus(1, 0, SEED_1, CT_5A, 4, 1'b1);
    checkOutput("to_cleared_on_go", timeoutB, 0);
    checkOutput("to_busy_again", busyB, 1);
    for (int i = 0; i < 200 && busyB; i++) @(negedge clk);
    checkOutput("to_flag_again", timeoutB, 1);

    $display("[TB] abort racing core_done");
    pushRuns(3, 1, CT_5A, SEED_1);
    applyStimulus(3, 1, SEED_1, CT_5A, 5, 1'b0);
    waitRunsDone(16'd1, 300);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!coreDone && n < 200);
    if (!coreDone) failNow("abort_wait_done_bound");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_core_start", coreStart, 0);
    checkOutput("abort_rand_req", randReq, 0);
    checkOutput("abort_ct_valid", ctValid, 0);
    checkOutput("abort_runs_done", runsDone, 1);
    checkOutput("abort_ct_kept", ctOut, CT_5A);
    repeat (3) @(negedge clk);
    checkOutput("abort_stays_idle", busy, 0);

    $display("[TB] plaintext stepping runs=2");
    pushRuns(2, 2, CT_C3, PT_SEED);
    applyStimulus(2, 0, PT_SEED, CT_C3, 3, 1'b0);
    checkOutput("pt_latched", ptOut, PT_SEED);
    waitIdle(300);
`ifdef SKINNY_SEQ_PT_INC_EN
    checkOutput("pt_second_run_model", ptAt(PT_SEED, 1), PT_NEXT);
    checkOutput("pt_after_batch", ptOut, PT_LAST);
`else
    checkOutput("pt_after_batch", ptOut, PT_SEED);
`endif

    $display("[TB] reset mid-batch");
    applyStimulus(2, 0, SEED_1, CT_A5, 50, 1'b0);
    n = 0;
    while (!coreStart && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!coreStart) failNow("rst_wait_run_bound");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_core_start", coreStart, 0);
    checkOutput("midrst_trigger", trigger, 0);
    checkOutput("midrst_rand_req", randReq, 0);
    checkOutput("midrst_runs_done", runsDone, 0);
    checkOutput("midrst_ct", ctOut, 0);
    checkOutput("midrst_pt", ptOut, 0);
    checkOutput("midrst_timeout_b", timeoutB, 0);
    rst = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
